pe_mac: RTL and testbench

PE_MAC -- requirements
Module: pe_mac

---
 rtl/pe_pkg.sv | 37 +++
 rtl/pe_mul_pipe.sv | 52 +++++
 rtl/pe_mac.sv | 136 +++++++++++++
 tb/tb_pe_mac.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared types and constants for the pe_mac processing element: parameter legality checks,
// the tag that travels with each product, and the saturation bound helpers.
package pe_pkg;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
    logic sgn;
  } tag_t;

  localparam int unsigned MaxAccW = 64;

  function automatic bit legal_data_w(int unsigned w);
    return (w == 8) || (w == 16) || (w == 32);
  endfunction

  function automatic bit legal_acc_w(int unsigned acc_w, int unsigned data_w);
    return (acc_w >= 2 * data_w) && (acc_w <= MaxAccW);
  endfunction

  function automatic bit legal_mul_lat(int unsigned lat);
    return (lat >= 1) && (lat <= 4);
  endfunction

  // Bounds are returned at MaxAccW bits; callers truncate to their accumulator width.
  function automatic logic [MaxAccW-1:0] sat_max(int unsigned acc_w, logic sgn);
    logic [MaxAccW-1:0] ones;
    ones = '1;
    return sgn ? (ones >> (MaxAccW - acc_w + 1)) : (ones >> (MaxAccW - acc_w));
  endfunction

  function automatic logic [MaxAccW-1:0] sat_min(int unsigned acc_w, logic sgn);
    return sgn ? ~sat_max(acc_w, 1'b1) : '0;
  endfunction

endpackage

// File: rtl/pe_mul_pipe.sv
// MUL_LAT-stage signed/unsigned multiplier; the operand tag shifts alongside the product.
module pe_mul_pipe
  import pe_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  tag_t                  tag_in,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output tag_t                  tag_out,
  output logic [2*DATA_W-1:0]   prod
);

  localparam int unsigned ProdW = 2 * DATA_W;

  logic signed [DATA_W:0] a_ext;
  logic signed [DATA_W:0] b_ext;
  logic [ProdW-1:0]       prod_d;

  tag_t             tag_q  [MUL_LAT];
  logic [ProdW-1:0] prod_q [MUL_LAT];

  // One extra bit lets a single signed multiply cover both operand modes.
  always_comb begin
    a_ext  = {tag_in.sgn & a[DATA_W-1], a};
    b_ext  = {tag_in.sgn & b[DATA_W-1], b};
    prod_d = ProdW'(a_ext) * ProdW'(b_ext);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(MUL_LAT); i++) begin
        tag_q[i]  <= '0;
        prod_q[i] <= '0;
      end
    end else begin
      tag_q[0]  <= tag_in;
      prod_q[0] <= prod_d;
      for (int i = 1; i < int'(MUL_LAT); i++) begin
        tag_q[i]  <= tag_q[i-1];
        prod_q[i] <= prod_q[i-1];
      end
    end
  end

  assign tag_out = tag_q[MUL_LAT-1];
  assign prod    = prod_q[MUL_LAT-1];

endmodule

// File: rtl/pe_mac.sv
// Systolic-array processing element: forwards operands one cycle and accumulates their
// products into a dot product, with optional saturation and a sticky overflow flag.
module pe_mac
  import pe_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ACC_W   = 20,
  parameter int unsigned MUL_LAT = 2,
  parameter bit          SAT     = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_first,
  input  logic              in_last,
  input  logic              signed_mode,
  input  logic [DATA_W-1:0] row_in,
  input  logic [DATA_W-1:0] col_in,
  output logic [DATA_W-1:0] row_out,
  output logic [DATA_W-1:0] col_out,
  output logic              fwd_valid,
  output logic              fwd_first,
  output logic              fwd_last,
  output logic              fwd_signed,
  output logic [ACC_W-1:0]  result_out,
  output logic              result_valid,
  output logic              result_ovf
);

  if (!legal_data_w(DATA_W)) begin : gen_bad_data_w
    $error("pe_mac: DATA_W must be 8, 16 or 32");
  end
  if (!legal_acc_w(ACC_W, DATA_W)) begin : gen_bad_acc_w
    $error("pe_mac: ACC_W must be at least 2*DATA_W");
  end
  if (!legal_mul_lat(MUL_LAT)) begin : gen_bad_mul_lat
    $error("pe_mac: MUL_LAT must be 1..4");
  end

  localparam logic [ACC_W-1:0] UMax = ACC_W'(sat_max(ACC_W, 1'b0));
  localparam logic [ACC_W-1:0] SMax = ACC_W'(sat_max(ACC_W, 1'b1));
  localparam logic [ACC_W-1:0] SMin = ACC_W'(sat_min(ACC_W, 1'b1));

  tag_t                issue_tag;
  tag_t                m_tag;
  logic [2*DATA_W-1:0] m_prod;

  logic [ACC_W-1:0] ext, sum, clamp;
  logic             carry, add_ovf;
  logic [ACC_W-1:0] acc_d, acc_q;
  logic             ovf_d, ovf_q;
  logic             res_pend_q;
  logic [ACC_W-1:0] result_q;
  logic             result_valid_q, result_ovf_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_out    <= '0;
      col_out    <= '0;
      fwd_valid  <= 1'b0;
      fwd_first  <= 1'b0;
      fwd_last   <= 1'b0;
      fwd_signed <= 1'b0;
    end else begin
      fwd_valid  <= in_valid;
      fwd_first  <= in_first;
      fwd_last   <= in_last;
      fwd_signed <= signed_mode;
      if (in_valid) begin
        row_out <= row_in;
        col_out <= col_in;
      end
    end
  end

  assign issue_tag = '{valid: in_valid, first: in_first, last: in_last, sgn: signed_mode};

  pe_mul_pipe #(
    .DATA_W  (DATA_W),
    .MUL_LAT (MUL_LAT)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (issue_tag),
    .a       (row_in),
    .b       (col_in),
    .tag_out (m_tag),
    .prod    (m_prod)
  );

  always_comb begin
    ext = m_tag.sgn ? ACC_W'($signed(m_prod)) : ACC_W'(m_prod);
    {carry, sum} = {1'b0, acc_q} + {1'b0, ext};
    // Signed overflow: like-signed operands producing a differently-signed sum.
    add_ovf = m_tag.sgn ? ((acc_q[ACC_W-1] == ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]))
                        : carry;
    clamp   = !m_tag.sgn ? UMax : (ext[ACC_W-1] ? SMin : SMax);
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    if (m_tag.valid) begin
      if (m_tag.first) begin
        acc_d = ext;
        ovf_d = 1'b0;
      end else if (!(SAT && ovf_q)) begin
        // Once saturated the accumulator is frozen until the next first beat.
        acc_d = (SAT && add_ovf) ? clamp : sum;
        ovf_d = ovf_q | add_ovf;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q          <= '0;
      ovf_q          <= 1'b0;
      res_pend_q     <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      result_ovf_q   <= 1'b0;
    end else begin
      acc_q          <= acc_d;
      ovf_q          <= ovf_d;
      res_pend_q     <= m_tag.valid & m_tag.last;
      result_valid_q <= res_pend_q;
      if (res_pend_q) begin
        result_q     <= acc_q;
        result_ovf_q <= ovf_q;
      end
    end
  end

  assign result_out   = result_q;
  assign result_valid = result_valid_q;
  assign result_ovf   = result_ovf_q;

endmodule

// File: tb/tb_pe_mac.sv
// Bench for pe_mac: wrap-around and saturating instances share stimulus and are checked
// against an arithmetic dot-product model.
module tb_pe_mac;

  localparam int unsigned DataW  = 8;
  localparam int unsigned AccW   = 20;
  localparam int unsigned MulLat = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_first, in_last, signed_mode;
  logic [DataW-1:0] row_in, col_in;

  logic [DataW-1:0] row_out0, col_out0, row_out1, col_out1;
  logic             fwd_valid0, fwd_first0, fwd_last0, fwd_signed0;
  logic             fwd_valid1, fwd_first1, fwd_last1, fwd_signed1;
  logic [AccW-1:0]  result_out0, result_out1;
  logic             result_valid0, result_valid1, result_ovf0, result_ovf1;

  always #5 clk = ~clk;

  pe_mac #(.DATA_W(DataW), .ACC_W(AccW), .MUL_LAT(MulLat), .SAT(1'b0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
    .signed_mode(signed_mode), .row_in(row_in), .col_in(col_in),
    .row_out(row_out0), .col_out(col_out0), .fwd_valid(fwd_valid0), .fwd_first(fwd_first0),
    .fwd_last(fwd_last0), .fwd_signed(fwd_signed0), .result_out(result_out0),
    .result_valid(result_valid0), .result_ovf(result_ovf0)
  );

  pe_mac #(.DATA_W(DataW), .ACC_W(AccW), .MUL_LAT(MulLat), .SAT(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
    .signed_mode(signed_mode), .row_in(row_in), .col_in(col_in),
    .row_out(row_out1), .col_out(col_out1), .fwd_valid(fwd_valid1), .fwd_first(fwd_first1),
    .fwd_last(fwd_last1), .fwd_signed(fwd_signed1), .result_out(result_out1),
    .result_valid(result_valid1), .result_ovf(result_ovf1)
  );

  typedef struct {
    int              due;
    logic [AccW-1:0] res0;
    logic [AccW-1:0] res1;
    bit              ovf0;
    bit              ovf1;
  } exp_t;

  exp_t            exp_q[$];
  longint          acc_m   [2];
  bit              ovf_m   [2];
  logic [AccW-1:0] last_res[2];
  logic [DataW-1:0] last_row, last_col;
  int              cyc;
  int              n_checks, n_errors;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Dot-product model on true integer values; s=1 is the saturating instance.
  task automatic model_beat(int s, bit f, bit sg, logic [DataW-1:0] a, logic [DataW-1:0] b);
    longint p, lo, hi, sum, r;
    p  = sg ? longint'($signed(a)) * longint'($signed(b)) : longint'(a) * longint'(b);
    lo = sg ? -(longint'(1) << (AccW - 1)) : 0;
    hi = sg ? (longint'(1) << (AccW - 1)) - 1 : (longint'(1) << AccW) - 1;
    if (f) begin
      acc_m[s] = p;
      ovf_m[s] = 1'b0;
    end else if (!(s == 1 && ovf_m[s])) begin
      sum = acc_m[s] + p;
      if (sum > hi || sum < lo) begin
        ovf_m[s] = 1'b1;
        if (s == 1) begin
          acc_m[s] = (sum > hi) ? hi : lo;
        end else begin
          r = sum & ((longint'(1) << AccW) - 1);
          if (sg && r > hi) r = r - (longint'(1) << AccW);
          acc_m[s] = r;
        end
      end else begin
        acc_m[s] = sum;
      end
    end
  endtask

  task automatic check_results();
    exp_t e;
    bit   due;
    due = (exp_q.size() > 0) && (exp_q[0].due == cyc);
    check("result_valid", 64'(result_valid0), 64'(due));
    check("result_valid_sat", 64'(result_valid1), 64'(due));
    if (due) begin
      e = exp_q.pop_front();
      last_res[0] = e.res0;
      last_res[1] = e.res1;
      check("result_ovf", 64'(result_ovf0), 64'(e.ovf0));
      check("result_ovf_sat", 64'(result_ovf1), 64'(e.ovf1));
    end
    check("result_out", 64'(result_out0), 64'(last_res[0]));
    check("result_out_sat", 64'(result_out1), 64'(last_res[1]));
  endtask

  task automatic step(bit v, bit f, bit l, bit sg, logic [DataW-1:0] a, logic [DataW-1:0] b);
    exp_t e;
    in_valid = v; in_first = f; in_last = l; signed_mode = sg; row_in = a; col_in = b;
    if (v) begin
      model_beat(0, f, sg, a, b);
      model_beat(1, f, sg, a, b);
      if (l) begin
        e.due  = cyc + 1 + int'(MulLat) + 1;
        e.res0 = AccW'(acc_m[0]);
        e.res1 = AccW'(acc_m[1]);
        e.ovf0 = ovf_m[0];
        e.ovf1 = ovf_m[1];
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    check("fwd_valid", 64'(fwd_valid0), 64'(v));
    if (v) begin
      last_row = a;
      last_col = b;
      check("fwd_first", 64'(fwd_first0), 64'(f));
      check("fwd_last", 64'(fwd_last0), 64'(l));
      check("fwd_signed", 64'(fwd_signed0), 64'(sg));
    end
    check("row_out", 64'(row_out0), 64'(last_row));
    check("col_out", 64'(col_out0), 64'(last_col));
    check_results();
  endtask

  task automatic idle();
    step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
  endtask

  task automatic check_zero(string tag);
    check({tag, "_row"}, 64'(row_out0), 64'd0);
    check({tag, "_col"}, 64'(col_out0), 64'd0);
    check({tag, "_fwd"}, 64'({fwd_valid0, fwd_first0, fwd_last0, fwd_signed0}), 64'd0);
    check({tag, "_res"}, 64'(result_out0), 64'd0);
    check({tag, "_flags"}, 64'({result_valid0, result_ovf0}), 64'd0);
    check({tag, "_res_sat"}, 64'(result_out1), 64'd0);
    check({tag, "_flags_sat"}, 64'({result_valid1, result_ovf1}), 64'd0);
  endtask

  task automatic clear_model();
    exp_q.delete();
    for (int s = 0; s < 2; s++) begin
      acc_m[s]    = 0;
      ovf_m[s]    = 1'b0;
      last_res[s] = '0;
    end
    last_row = '0;
    last_col = '0;
  endtask

  // Reset lands mid-cycle so its effect must be combinationally immediate.
  task automatic apply_reset();
    #2 rst = 1'b0;
    #1 check_zero("reset_now");
    clear_model();
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      cyc++;
      check("reset_fwd_valid", 64'(fwd_valid0), 64'd0);
      check_results();
    end
    #1 rst = 1'b1;
  endtask

  task automatic dot(bit sg, int n, logic [DataW-1:0] a, logic [DataW-1:0] b);
    for (int k = 0; k < n; k++) step(1'b1, k == 0, k == n - 1, sg, a, b);
  endtask

  int   rem;
  bit   cur_sg, f_bit;
  logic [DataW-1:0] ra, rb;

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0;
    rst = 1'b0;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; signed_mode = 1'b0;
    row_in = '0; col_in = '0;
    clear_model();
    #3 check_zero("reset_init");
    @(posedge clk);
    #2 rst = 1'b1;

    // Products before any first start from zero.
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'd5, 8'd5);
    repeat (2) idle();
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'd3, 8'd4);
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'd5, 8'd6);
    repeat (4) idle();
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'hFE, 8'd7);
    repeat (4) idle();
    dot(1'b0, 17, 8'd255, 8'd255);
    repeat (4) idle();
    for (int k = 1; k <= 4; k++) step(1'b1, 1'b1, 1'b1, 1'b0, 8'(k), 8'(k));
    repeat (4) idle();

    // Signed overflow upward, then a negative term that the saturating copy must ignore.
    for (int k = 0; k < 40; k++) step(1'b1, k == 0, 1'b0, 1'b1, 8'h80, 8'h80);
    step(1'b1, 1'b0, 1'b1, 1'b1, 8'h80, 8'h7F);
    dot(1'b1, 40, 8'h80, 8'h7F);
    repeat (4) idle();

    // Reset with two products in flight.
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'd3, 8'd3);
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'd4, 8'd4);
    apply_reset();
    repeat (5) idle();
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'd9, 8'd9);
    repeat (4) idle();

    rem = 0;
    cur_sg = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 7) begin
        f_bit = 1'b0;
        if (rem == 0) begin
          rem    = $urandom_range(1, 24);
          cur_sg = 1'($urandom);
          f_bit  = 1'b1;
        end
        ra = ($urandom_range(0, 3) == 0) ? (cur_sg ? 8'h80 : 8'hFF) : 8'($urandom);
        rb = ($urandom_range(0, 3) == 0) ? (cur_sg ? 8'h80 : 8'hFF) : 8'($urandom);
        step(1'b1, f_bit, rem == 1, cur_sg, ra, rb);
        rem--;
      end else begin
        idle();
      end
    end
    repeat (6) idle();
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
